// File: rtl/rover_move_executor_if.sv
// Move-command bus between the IR frame decoder side and the rover move executor.
//   cmd_valid/cmd/abort : command side, driven by the master
//   motor_turn/motor_fwd/busy/done/last_cmd/state : executor status, driven by the slave
interface rover_move_executor_if;
  logic        cmd_valid;
  logic [11:0] cmd;
  logic        abort;
  logic        motor_turn;
  logic        motor_fwd;
  logic        busy;
  logic        done;
  logic [11:0] last_cmd;
  logic [1:0]  state;

  modport master (
    output cmd_valid, cmd, abort,
    input  motor_turn, motor_fwd, busy, done, last_cmd, state
  );

  modport slave (
    input  cmd_valid, cmd, abort,
    output motor_turn, motor_fwd, busy, done, last_cmd, state
  );
endinterface

// File: rtl/rover_move_executor.sv
// Rover move executor: accepts 12-bit move frames (r = cmd[7:0], theta = cmd[11:8]),
// filters the repeated copies the base station sends, then turns for theta units and
// drives forward for r units, UNIT_CYCLES clock cycles per unit.
// Ports:
//   clock - system clock
//   reset - asynchronous, active-high
//   bus   - slave side of rover_move_executor_if (command in, motors/status out)
module rover_move_executor #(
  parameter int UNIT_CYCLES  = 27000000,
  parameter int REARM_CYCLES = 27000000
) (
  input logic                  clock,
  input logic                  reset,
  rover_move_executor_if.slave bus
);
  localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int QW = $clog2(REARM_CYCLES + 1);
  localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);
  localparam logic [QW-1:0] QUIET_MAX = QW'(REARM_CYCLES);
  localparam logic [QW-1:0] QUIET_ARM = QW'(REARM_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, TURN = 2'd1, DRIVE = 2'd2, FINISH = 2'd3} state_t;

  state_t        st;
  logic [UW-1:0] unit_ctr;
  logic [7:0]    units_left;
  logic [QW-1:0] quiet_ctr;
  logic          armed;
  logic [11:0]   last_cmd;
  logic          motor_turn, motor_fwd, busy, done;
  logic          accept, unit_end, last_unit;

  // A repeat of the last command is only taken once the link has been quiet long enough.
  assign accept    = (st == IDLE) && bus.cmd_valid && !bus.abort &&
                     ((bus.cmd != last_cmd) || armed);
  assign unit_end  = (unit_ctr == UNIT_LAST);
  assign last_unit = unit_end && (units_left == 8'd1);

  // Quiet-time tracker: any strobe restarts the count; reaching REARM_CYCLES arms once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      quiet_ctr <= '0;
      armed     <= 1'b1;
    end else if (bus.cmd_valid) begin
      quiet_ctr <= '0;
      armed     <= 1'b0;
    end else begin
      if (quiet_ctr != QUIET_MAX) quiet_ctr <= quiet_ctr + QW'(1);
      if (bus.abort)                   armed <= 1'b0;
      else if (quiet_ctr == QUIET_ARM) armed <= 1'b1;
    end
  end

  // Move FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st         <= IDLE;
      unit_ctr   <= '0;
      units_left <= '0;
      last_cmd   <= 12'h000;
      motor_turn <= 1'b0;
      motor_fwd  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (bus.abort) begin
      st         <= IDLE;
      motor_turn <= 1'b0;
      motor_fwd  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          done <= 1'b0;
          if (accept) begin
            last_cmd <= bus.cmd;
            unit_ctr <= '0;
            if (bus.cmd[11:8] != 4'd0) begin
              st         <= TURN;
              units_left <= {4'd0, bus.cmd[11:8]};
              motor_turn <= 1'b1;
              busy       <= 1'b1;
            end else if (bus.cmd[7:0] != 8'd0) begin
              st         <= DRIVE;
              units_left <= bus.cmd[7:0];
              motor_fwd  <= 1'b1;
              busy       <= 1'b1;
            end else begin
              st   <= FINISH;
              done <= 1'b1;
            end
          end
        end
        TURN: begin
          if (unit_end) begin
            unit_ctr   <= '0;
            units_left <= units_left - 8'd1;
            if (last_unit) begin
              motor_turn <= 1'b0;
              if (last_cmd[7:0] != 8'd0) begin
                // later assignment overrides the decrement above
                st         <= DRIVE;
                units_left <= last_cmd[7:0];
                motor_fwd  <= 1'b1;
              end else begin
                st   <= FINISH;
                busy <= 1'b0;
                done <= 1'b1;
              end
            end
          end else begin
            unit_ctr <= unit_ctr + UW'(1);
          end
        end
        DRIVE: begin
          if (unit_end) begin
            unit_ctr   <= '0;
            units_left <= units_left - 8'd1;
            if (last_unit) begin
              st        <= FINISH;
              motor_fwd <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end else begin
            unit_ctr <= unit_ctr + UW'(1);
          end
        end
        FINISH: begin
          st   <= IDLE;
          done <= 1'b0;
        end
      endcase
    end
  end

  assign bus.motor_turn = motor_turn;
  assign bus.motor_fwd  = motor_fwd;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.last_cmd   = last_cmd;
  assign bus.state      = st;
endmodule

// File: tb/tb_rover_move_executor.sv
// Bench for rover_move_executor with UNIT_CYCLES=4, REARM_CYCLES=8: directed scenarios
// with literal expectations plus randomized traffic, all checked every cycle against a
// timeline model (acceptance time + theta/r determine the expected outputs).
module tb_rover_move_executor;
  localparam int U = 4;
  localparam int R = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  rover_move_executor_if bus();

  rover_move_executor #(.UNIT_CYCLES(U), .REARM_CYCLES(R)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // ---------------- behavioural model ----------------
  int          cyc = 0;
  bit          m_active = 0;
  int          m_t0 = 0, m_th = 0, m_r = 0;
  logic [11:0] m_last = 12'h000;
  bit          m_armed = 1;
  int          m_quiet = 0;
  logic [1:0]  e_state = 2'd0;
  logic        e_turn = 0, e_fwd = 0, e_done = 0, e_busy = 0;

  always @(posedge clock) begin
    bit prev_idle, acc;
    int k, len;
    if (reset) begin
      m_active = 0; m_last = 12'h000; m_armed = 1; m_quiet = 0;
    end else begin
      cyc++;
      prev_idle = (e_state == 2'd0);
      acc = bus.cmd_valid && !bus.abort && prev_idle && ((bus.cmd != m_last) || m_armed);
      if (bus.cmd_valid) begin
        m_quiet = 0; m_armed = 0;
      end else begin
        m_quiet++;
        if (m_quiet == R) m_armed = 1;
        if (bus.abort) m_armed = 0;
      end
      if (bus.abort) m_active = 0;
      else if (acc) begin
        m_active = 1; m_t0 = cyc; m_last = bus.cmd;
        m_th = int'(bus.cmd[11:8]); m_r = int'(bus.cmd[7:0]);
      end
    end
    k = cyc - m_t0;
    len = (m_th + m_r) * U;
    if (m_active && k > len) m_active = 0;
    e_turn = m_active && (k < m_th * U);
    e_fwd  = m_active && (k >= m_th * U) && (k < len);
    e_done = m_active && (k == len);
    e_busy = e_turn || e_fwd;
    e_state = e_turn ? 2'd1 : e_fwd ? 2'd2 : e_done ? 2'd3 : 2'd0;
    #1;
    vectors++;
    if ({bus.state, bus.motor_turn, bus.motor_fwd, bus.busy, bus.done, bus.last_cmd} !==
        {e_state, e_turn, e_fwd, e_busy, e_done, m_last}) begin
      miscompares++;
      $display("FAIL cycle_check t=%0t got state=%0d turn=%b fwd=%b busy=%b done=%b last=%h want state=%0d turn=%b fwd=%b busy=%b done=%b last=%h",
               $time, bus.state, bus.motor_turn, bus.motor_fwd, bus.busy, bus.done, bus.last_cmd,
               e_state, e_turn, e_fwd, e_busy, e_done, m_last);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock); #2;
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic strobe(input logic [11:0] c);
    bus.cmd_valid = 1'b1; bus.cmd = c;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // dat = cycles from the strobe cycle to the first done pulse (-1 if none)
  task automatic count_run(input int n, output int nt, output int nf, output int nd, output int dat);
    nt = 0; nf = 0; nd = 0; dat = -1;
    for (int i = 0; i < n; i++) begin
      if (bus.motor_turn) nt++;
      if (bus.motor_fwd) nf++;
      if (bus.done) begin nd++; if (dat < 0) dat = i + 1; end
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int nt, nf, nd, dat;
    logic [11:0] pool [4];
    bus.cmd_valid = 1'b0; bus.cmd = 12'h000; bus.abort = 1'b0;
    tick(); tick();
    check("reset_state", int'(bus.state), 0);
    check("reset_last_cmd", int'(bus.last_cmd), 0);
    reset = 1'b0;
    tick();

    // basic move
    strobe(12'h20A);
    count_run(60, nt, nf, nd, dat);
    check("basic_turn_cycles", nt, 8);
    check("basic_fwd_cycles", nf, 40);
    check("basic_done_latency", dat, 49);
    check("basic_done_count", nd, 1);
    check("basic_last_cmd", int'(bus.last_cmd), 'h20A);

    // repeat filter: strobes every 3 cycles
    nt = 0; nf = 0; nd = 0;
    for (int i = 0; i < 100; i++) begin
      bus.cmd_valid = (i % 3 == 0); bus.cmd = 12'h00A;
      if (bus.motor_turn) nt++;
      if (bus.motor_fwd) nf++;
      if (bus.done) nd++;
      tick();
    end
    bus.cmd_valid = 1'b0;
    begin
      int t2, f2, d2, a2;
      count_run(20, t2, f2, d2, a2);
      check("repeat_fwd_cycles", nf + f2, 40);
      check("repeat_done_count", nd + d2, 1);
      check("repeat_turn_cycles", nt + t2, 0);
    end

    // re-arm after quiet period, then a different command right away
    strobe(12'h00A);
    count_run(45, nt, nf, nd, dat);
    check("rearm_fwd_cycles", nf, 40);
    check("rearm_done_latency", dat, 41);
    strobe(12'h105);
    count_run(30, nt, nf, nd, dat);
    check("diff_turn_cycles", nt, 4);
    check("diff_fwd_cycles", nf, 20);
    check("diff_done_latency", dat, 25);

    // zero move after reset, then turn-only move
    reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
    strobe(12'h000);
    count_run(5, nt, nf, nd, dat);
    check("zero_done_latency", dat, 1);
    check("zero_motor_cycles", nt + nf, 0);
    strobe(12'h300);
    count_run(20, nt, nf, nd, dat);
    check("turnonly_turn_cycles", nt, 12);
    check("turnonly_fwd_cycles", nf, 0);
    check("turnonly_done_latency", dat, 13);

    // abort at DRIVE cycle 5
    strobe(12'h003);
    repeat (4) tick();
    check("abort_pre_fwd", int'(bus.motor_fwd), 1);
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    check("abort_state", int'(bus.state), 0);
    check("abort_motors", int'({bus.motor_turn, bus.motor_fwd}), 0);
    count_run(20, nt, nf, nd, dat);
    check("abort_no_done", nd, 0);
    bus.cmd_valid = 1'b1; bus.cmd = 12'h0F0; bus.abort = 1'b1;
    tick();
    bus.cmd_valid = 1'b0; bus.abort = 1'b0;
    check("abort_cmd_state", int'(bus.state), 0);
    count_run(5, nt, nf, nd, dat);
    check("abort_cmd_no_move", nt + nf + nd, 0);

    // asynchronous reset mid-TURN
    strobe(12'h500);
    repeat (3) tick();
    check("areset_pre_turn", int'(bus.motor_turn), 1);
    #3 reset = 1'b1;
    #1;
    check("areset_turn_drop", int'(bus.motor_turn), 0);
    check("areset_last_cmd", int'(bus.last_cmd), 0);
    check("areset_state", int'(bus.state), 0);
    tick();
    reset = 1'b0;
    tick();
    strobe(12'h000);
    count_run(3, nt, nf, nd, dat);
    check("areset_zero_accept", dat, 1);

    // randomized traffic from a small command pool so repeats are common
    for (int i = 0; i < 4; i++) begin
      logic [3:0] th;
      logic [7:0] r;
      th = 4'($urandom_range(0, 3));
      r = 8'($urandom_range(0, 5));
      pool[i] = {th, r};
    end
    for (int i = 0; i < 3000; i++) begin
      bus.cmd_valid = ($urandom_range(0, 5) == 0);
      bus.cmd = pool[$urandom_range(0, 3)];
      bus.abort = ($urandom_range(0, 49) == 0);
      tick();
    end
    bus.cmd_valid = 1'b0; bus.abort = 1'b0;
    repeat (50) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rover_move_executor.md
# rover_move_executor

Rover-side responder for the base station's IR move command. It accepts decoded 12-bit move frames (r in [7:0], theta in [11:8]) and ignores the repeated copies the base sends during its one-second transmit window. It executes each accepted move by turning for theta units and then driving forward for r units, with every unit lasting a fixed number of cycles. This matches the base station's wait of MOVE_DELAY_FACTOR × (r + theta) cycles.

## Interface
- UNIT_CYCLES, 27000000: clock cycles per turn unit and per distance unit (≥2).
- REARM_CYCLES, 27000000: quiet cycles (no cmd_valid) after which a repeat of the last command is accepted again.
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high; one clock.
- cmd_valid  input  1  one-cycle strobe from the IR frame decoder.
- cmd  input  12  frame payload; r = cmd[7:0], theta = cmd[11:8]; sampled only when cmd_valid=1.
- abort  input  1  synchronous stop request.
- motor_turn  output  1  turn-in-place drive enable.
- motor_fwd  output  1  forward drive enable.
- busy  output  1  high while a move is executing (TURN or DRIVE).
- done  output  1  one-cycle pulse on move completion.
- last_cmd  output  12  most recently accepted command.
- state  output  2  FSM state, exposed for debug.

## Operation
- States: IDLE=0, TURN=1, DRIVE=2, FINISH=3.
- Registers:
  - unit_ctr: counts cycles within a unit, from 0 to UNIT_CYCLES-1.
  - units_left: 8 bits.
  - quiet_ctr: saturates at REARM_CYCLES.
  - armed flag.
- Frame acceptance, in IDLE only:
  - A frame with cmd_valid=1 is accepted if cmd != last_cmd, or if armed=1.
  - All frames seen in TURN, DRIVE or FINISH are dropped.
  - A frame that is not accepted in IDLE is dropped and does not restart a move.
- Re-arm:
  - Every cycle with cmd_valid=1 clears quiet_ctr to 0 and clears armed, in any state.
  - Otherwise quiet_ctr increments.
  - When quiet_ctr reaches REARM_CYCLES, armed is set to 1.
  - On acceptance, armed is cleared.
- On acceptance:
  - Load last_cmd ← cmd.
  - If theta≠0: go to TURN with units_left ← theta.
  - Else if r≠0: go to DRIVE with units_left ← r.
  - Else (r=theta=0): go to FINISH.
  - unit_ctr ← 0.
- TURN:
  - motor_turn=1.
  - unit_ctr counts up. At UNIT_CYCLES-1 it wraps to 0 and units_left decrements.
  - When the last unit ends, go to DRIVE with units_left ← last_cmd[7:0] if r≠0, else go to FINISH.
- DRIVE:
  - motor_fwd=1, with the same counting rule as TURN.
  - When the last unit ends, go to FINISH.
- FINISH: done=1 for one cycle, then go to IDLE.
- motor_turn and motor_fwd are never high together.
- abort=1 in any state:
  - Next state is IDLE and both motors are off next cycle.
  - No done pulse.
  - last_cmd is kept; armed is cleared.
  - abort takes priority over a simultaneous cmd_valid.
- Reset (asynchronous, mid-move included):
  - state=IDLE; motors, busy and done = 0.
  - last_cmd=12'h000; armed=1; counters=0.
  - A pending move is discarded.

## Timing
- Outputs are registered. Accepting a frame at edge N gives state and motor change visible after edge N+1.
- motor_turn is high for exactly theta×UNIT_CYCLES cycles.
- motor_fwd follows with no gap and is high for exactly r×UNIT_CYCLES cycles.
- done asserts the cycle after the last motor cycle.
- Total latency from acceptance to done is (theta+r)×UNIT_CYCLES + 1 cycles. A zero move gives done one cycle after acceptance.
- busy = (state==TURN || state==DRIVE).
- An accepted command can be followed by a new acceptance no earlier than the cycle after FINISH.
- Maximum move: 255 distance units plus 15 turn units. units_left never underflows.

## Test plan
All scenarios use UNIT_CYCLES=4 and REARM_CYCLES=8.
- Basic move: after reset, a cmd=12'h20A strobe gives motor_turn high for 8 cycles, then motor_fwd high for 40 cycles, then a one-cycle done pulse 49 cycles after acceptance; last_cmd=12'h20A.
- Repeat filter: 12'h00A is strobed every 3 cycles for 100 cycles. Exactly one move executes (40 fwd cycles, one done); quiet_ctr never reaches 8, so no second move follows.
- Re-arm: after the 12'h00A move completes, 8 quiet cycles pass and then 12'h00A is strobed again. A second move executes. A different command (12'h105) is accepted immediately in IDLE with no quiet period.
- Zero and turn-only moves:
  - cmd=12'h000 after reset (armed=1) gives done one cycle after acceptance, with no motor activity.
  - cmd=12'h300 gives 12 turn cycles, then done, and motor_fwd never rises.
- Abort: abort pulses at cycle 5 of DRIVE for cmd=12'h003. Motors are 0 on the next cycle, state=IDLE, and there is no done. A simultaneous cmd_valid+abort in IDLE does not start a move.
- Asynchronous reset mid-TURN: reset asserts between clock edges. motor_turn drops immediately, last_cmd=12'h000, and the next 12'h000 frame is accepted.
